// File: rtl/hdmi_cfg_scheduler.sv
// Round-robin arbiter for the HDMI controller's single configuration port.
// Coalesces accepted writes and releases the last one as a strobe at vertical blanking start.
module hdmi_cfg_scheduler #(
  parameter int          NUM_REQ  = 2,
  parameter int          HA       = 640,
  parameter int          HMAX     = 800,
  parameter int          VA       = 480,
  parameter int          VMAX     = 525,
  parameter logic [31:0] CFG_INIT = 32'h0000_0001
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [32*NUM_REQ-1:0]     i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic [$clog2(HMAX)-1:0]   i_hcount,
  input  logic [$clog2(VMAX)-1:0]   i_vcount,
  output logic                      o_cfg_valid,
  output logic [31:0]               o_cfg_data,
  output logic                      o_pending,
  output logic [7:0]                o_apply_count
);

  localparam int HC_W  = $clog2(HMAX);
  localparam int VC_W  = $clog2(VMAX);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [VC_W-1:0] APPLY_V = VC_W'(VA);
  localparam logic [HC_W-1:0] APPLY_H = '0;

  // A frame with no horizontal or vertical blanking has no safe apply point.
  if (NUM_REQ < 2 || NUM_REQ > 8 || HA >= HMAX || VA >= VMAX) begin : g_badParams
    $error("hdmi_cfg_scheduler: invalid parameter set");
  end

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    APPLY
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [PTR_W-1:0]   r_rrPtr;
  logic [PTR_W-1:0]   w_grantIdx;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_found;
  logic               w_applyPt;
  logic               w_blockGrant;
  logic               w_accept;
  logic [31:0]        w_reqWord;
  logic [31:0]        r_pendingData;
  logic [31:0]        r_cfgData;
  logic [7:0]         r_applyCount;

  function automatic logic [PTR_W-1:0] wrapIdx(input int v);
    return PTR_W'(v % NUM_REQ);
  endfunction

  assign w_applyPt    = (i_vcount == APPLY_V) && (i_hcount == APPLY_H);
  // No grant while the pending word is being released, so it cannot change under the strobe.
  assign w_blockGrant = (r_state == APPLY) || ((r_state == PENDING) && w_applyPt);
  assign w_accept     = |w_grant;
  assign w_reqWord    = i_req_data[32*int'(w_grantIdx) +: 32];

  assign o_req_ready   = w_grant;
  assign o_cfg_data    = r_cfgData;
  assign o_apply_count = r_applyCount;

  always_comb begin
    w_found    = 1'b0;
    w_grantIdx = r_rrPtr;
    w_grant    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_req_valid[wrapIdx(int'(r_rrPtr) + i)]) begin
        w_found    = 1'b1;
        w_grantIdx = wrapIdx(int'(r_rrPtr) + i);
      end
    end
    if (w_found && !w_blockGrant) begin
      w_grant[w_grantIdx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    o_cfg_valid = 1'b0;
    o_pending   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState = PENDING;
        end
      end
      PENDING: begin
        o_pending = 1'b1;
        if (w_applyPt) begin
          w_nextState = APPLY;
        end
      end
      APPLY: begin
        o_cfg_valid = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rrPtr       <= '0;
      r_pendingData <= CFG_INIT;
      r_cfgData     <= CFG_INIT;
      r_applyCount  <= 8'd0;
    end else begin
      if (w_accept) begin
        r_pendingData <= w_reqWord;
        r_rrPtr       <= wrapIdx(int'(w_grantIdx) + 1);
      end
      if ((r_state == PENDING) && w_applyPt) begin
        r_cfgData    <= r_pendingData;
        r_applyCount <= r_applyCount + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_cfg_scheduler.sv
// Directed bench for hdmi_cfg_scheduler on a shrunken 10x8 raster (apply point at v=6, h=0).
// Inputs change 1 time unit after each rising edge; outputs are sampled on the falling edge.
module tb_hdmi_cfg_scheduler;

  localparam int NUM_REQ = 2;
  localparam int HA      = 8;
  localparam int HMAX    = 10;
  localparam int VA      = 6;
  localparam int VMAX    = 8;
  localparam int HC_W    = $clog2(HMAX);
  localparam int VC_W    = $clog2(VMAX);

  logic                  clk = 1'b0;
  logic                  rstn;
  logic [NUM_REQ-1:0]    i_req_valid;
  logic [32*NUM_REQ-1:0] i_req_data;
  logic [NUM_REQ-1:0]    o_req_ready;
  logic [HC_W-1:0]       i_hcount;
  logic [VC_W-1:0]       i_vcount;
  logic                  o_cfg_valid;
  logic [31:0]           o_cfg_data;
  logic                  o_pending;
  logic [7:0]            o_apply_count;

  int          compared    = 0;
  int          mismatched  = 0;
  int          hc          = 0;
  int          vc          = 0;
  int          strobeCount = 0;
  int          strobeH     = -1;
  int          strobeV     = -1;
  logic [31:0] strobeData  = '0;

  hdmi_cfg_scheduler #(
    .NUM_REQ (NUM_REQ),
    .HA      (HA),
    .HMAX    (HMAX),
    .VA      (VA),
    .VMAX    (VMAX),
    .CFG_INIT(32'h0000_0001)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_req_valid  (i_req_valid),
    .i_req_data   (i_req_data),
    .o_req_ready  (o_req_ready),
    .i_hcount     (i_hcount),
    .i_vcount     (i_vcount),
    .o_cfg_valid  (o_cfg_valid),
    .o_cfg_data   (o_cfg_data),
    .o_pending    (o_pending),
    .o_apply_count(o_apply_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One clock cycle: advance the raster, drive requests, then sample on the falling edge.
  task automatic applyStimulus(input logic [1:0] valid, input logic [31:0] d0, input logic [31:0] d1);
    @(posedge clk);
    #1;
    hc++;
    if (hc == HMAX) begin
      hc = 0;
      vc = (vc + 1) % VMAX;
    end
    i_hcount    = HC_W'(hc);
    i_vcount    = VC_W'(vc);
    i_req_valid = valid;
    i_req_data  = {d1, d0};
    @(negedge clk);
    if (o_cfg_valid) begin
      strobeCount++;
      strobeH    = hc;
      strobeV    = vc;
      strobeData = o_cfg_data;
    end
  endtask

  // Idle until the next cycle to be driven is raster position (v, h).
  task automatic runUntil(input int v, input int h);
    for (int n = 0; n < 2 * HMAX * VMAX; n++) begin
      int nh;
      int nv;
      nh = hc + 1;
      nv = vc;
      if (nh == HMAX) begin
        nh = 0;
        nv = (vc + 1) % VMAX;
      end
      if ((nh == h) && (nv == v)) return;
      applyStimulus(2'b00, 32'h0, 32'h0);
    end
    compared++;
    mismatched++;
    $error("[TB] FAIL runUntil: position (%0d,%0d) not reached, at (%0d,%0d)", v, h, vc, hc);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rstn        = 1'b0;
    i_req_valid = '0;
    i_req_data  = '0;
    i_hcount    = '0;
    i_vcount    = '0;

    repeat (3) applyStimulus(2'b00, 32'h0, 32'h0);
    checkOutput("reset_cfg_valid", 32'(o_cfg_valid), 32'd0);
    checkOutput("reset_cfg_data", o_cfg_data, 32'h0000_0001);
    checkOutput("reset_pending", 32'(o_pending), 32'd0);
    checkOutput("reset_apply_count", 32'(o_apply_count), 32'd0);
    rstn        = 1'b1;
    strobeCount = 0;

    repeat (2 * HMAX * VMAX) applyStimulus(2'b00, 32'h0, 32'h0);
    checkOutput("idle_strobes", 32'(strobeCount), 32'd0);
    checkOutput("idle_cfg_data", o_cfg_data, 32'h0000_0001);
    checkOutput("idle_apply_count", 32'(o_apply_count), 32'd0);

    // Both requesters valid from rr_ptr = 0: grants alternate, last accepted word wins.
    runUntil(1, 0);
    strobeCount = 0;
    applyStimulus(2'b11, 32'hA000_0000, 32'hB000_0000);
    checkOutput("rr_grant_c0", 32'(o_req_ready), 32'd1);
    applyStimulus(2'b11, 32'hA000_0001, 32'hB000_0000);
    checkOutput("rr_grant_c1", 32'(o_req_ready), 32'd2);
    applyStimulus(2'b11, 32'hA000_0001, 32'hB000_0001);
    checkOutput("rr_grant_c2", 32'(o_req_ready), 32'd1);
    applyStimulus(2'b11, 32'hA000_0002, 32'hB000_0001);
    checkOutput("rr_grant_c3", 32'(o_req_ready), 32'd2);
    applyStimulus(2'b00, 32'h0, 32'h0);
    checkOutput("rr_pending", 32'(o_pending), 32'd1);
    runUntil(6, 0);
    applyStimulus(2'b00, 32'h0, 32'h0);
    checkOutput("rr_applypt_pending", 32'(o_pending), 32'd1);
    checkOutput("rr_applypt_no_strobe", 32'(o_cfg_valid), 32'd0);
    applyStimulus(2'b00, 32'h0, 32'h0);
    checkOutput("rr_strobe", 32'(o_cfg_valid), 32'd1);
    checkOutput("rr_strobe_data", o_cfg_data, 32'hB000_0001);
    checkOutput("rr_strobe_pending", 32'(o_pending), 32'd0);
    applyStimulus(2'b00, 32'h0, 32'h0);
    checkOutput("rr_after_valid", 32'(o_cfg_valid), 32'd0);
    checkOutput("rr_apply_count", 32'(o_apply_count), 32'd1);
    checkOutput("rr_strobe_v", 32'(strobeV), 32'd6);
    checkOutput("rr_strobe_h", 32'(strobeH), 32'd1);

    // Requester 0 writes zero mid-frame; applied once at the apply point.
    runUntil(2, 0);
    checkOutput("rr_strobe_total", 32'(strobeCount), 32'd1);
    strobeCount = 0;
    applyStimulus(2'b01, 32'h0000_0000, 32'h0);
    checkOutput("w0_grant", 32'(o_req_ready), 32'd1);
    applyStimulus(2'b00, 32'h0, 32'h0);
    checkOutput("w0_pending", 32'(o_pending), 32'd1);
    runUntil(6, 1);
    applyStimulus(2'b00, 32'h0, 32'h0);
    checkOutput("w0_strobe", 32'(o_cfg_valid), 32'd1);
    checkOutput("w0_strobe_data", o_cfg_data, 32'h0000_0000);
    applyStimulus(2'b00, 32'h0, 32'h0);
    checkOutput("w0_apply_count", 32'(o_apply_count), 32'd2);
    checkOutput("w0_strobe_total", 32'(strobeCount), 32'd1);

    // Request on the apply point while IDLE: accepted, applied a frame later.
    runUntil(6, 0);
    strobeCount = 0;
    applyStimulus(2'b10, 32'h0, 32'hC0FF_EE01);
    checkOutput("idleapt_grant", 32'(o_req_ready), 32'd2);
    applyStimulus(2'b00, 32'h0, 32'h0);
    checkOutput("idleapt_no_strobe", 32'(o_cfg_valid), 32'd0);
    checkOutput("idleapt_pending", 32'(o_pending), 32'd1);
    runUntil(6, 0);
    applyStimulus(2'b00, 32'h0, 32'h0);
    checkOutput("idleapt_strobes_before", 32'(strobeCount), 32'd0);
    applyStimulus(2'b00, 32'h0, 32'h0);
    checkOutput("idleapt_strobe", 32'(o_cfg_valid), 32'd1);
    checkOutput("idleapt_strobe_data", o_cfg_data, 32'hC0FF_EE01);
    applyStimulus(2'b00, 32'h0, 32'h0);
    checkOutput("idleapt_apply_count", 32'(o_apply_count), 32'd3);

    // Request on the apply point while PENDING: held off through APPLY, then accepted.
    runUntil(3, 0);
    applyStimulus(2'b01, 32'hD000_0000, 32'h0);
    checkOutput("pendapt_first_grant", 32'(o_req_ready), 32'd1);
    runUntil(6, 0);
    applyStimulus(2'b10, 32'h0, 32'hE1E1_0001);
    checkOutput("pendapt_ready_apt", 32'(o_req_ready), 32'd0);
    applyStimulus(2'b10, 32'h0, 32'hE1E1_0001);
    checkOutput("pendapt_ready_apply", 32'(o_req_ready), 32'd0);
    checkOutput("pendapt_strobe", 32'(o_cfg_valid), 32'd1);
    checkOutput("pendapt_strobe_data", o_cfg_data, 32'hD000_0000);
    applyStimulus(2'b10, 32'h0, 32'hE1E1_0001);
    checkOutput("pendapt_ready_idle", 32'(o_req_ready), 32'd2);
    applyStimulus(2'b00, 32'h0, 32'h0);
    checkOutput("pendapt_pending", 32'(o_pending), 32'd1);
    checkOutput("pendapt_apply_count", 32'(o_apply_count), 32'd4);
    runUntil(6, 1);
    applyStimulus(2'b00, 32'h0, 32'h0);
    checkOutput("pendapt_second_strobe", 32'(o_cfg_valid), 32'd1);
    checkOutput("pendapt_second_data", o_cfg_data, 32'hE1E1_0001);
    applyStimulus(2'b00, 32'h0, 32'h0);
    checkOutput("pendapt_apply_count2", 32'(o_apply_count), 32'd5);

    // Reset while PENDING discards the held word.
    runUntil(2, 0);
    applyStimulus(2'b01, 32'hDEAD_BEEF, 32'h0);
    checkOutput("rst_grant", 32'(o_req_ready), 32'd1);
    applyStimulus(2'b00, 32'h0, 32'h0);
    checkOutput("rst_pending_before", 32'(o_pending), 32'd1);
    rstn = 1'b0;
    applyStimulus(2'b00, 32'h0, 32'h0);
    rstn = 1'b1;
    checkOutput("rst_pending_after", 32'(o_pending), 32'd0);
    checkOutput("rst_apply_count", 32'(o_apply_count), 32'd0);
    strobeCount = 0;
    runUntil(7, 0);
    applyStimulus(2'b00, 32'h0, 32'h0);
    checkOutput("rst_no_strobe", 32'(strobeCount), 32'd0);
    checkOutput("rst_cfg_data", o_cfg_data, 32'h0000_0001);
    checkOutput("rst_pending_frame", 32'(o_pending), 32'd0);

    // 256 applies wrap the counter back to zero.
    strobeCount = 0;
    for (int f = 0; f < 256; f++) begin
      runUntil(1, 0);
      applyStimulus(2'b01, 32'(f), 32'h0);
      runUntil(6, 2);
      applyStimulus(2'b00, 32'h0, 32'h0);
      if (f == 254) begin
        checkOutput("wrap_count_255", 32'(o_apply_count), 32'd255);
      end
    end
    checkOutput("wrap_count_0", 32'(o_apply_count), 32'd0);
    checkOutput("wrap_strobes", 32'(strobeCount), 32'd256);
    checkOutput("wrap_last_data", o_cfg_data, 32'h0000_00FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
